snn_bram_mailbox: RTL and testbench
===================================

Name: snn_bram_mailbox

Overview:
- BRAM port-B master that sits between the MicroBlaze block-design BRAM and the network wrapper's input and output spike streams.
- Polls a doorbell word written by firmware, then fetches the input spike words and streams them to the network over valid/ready.
- Collects the output spike words from the network, writes them back to BRAM, then posts a status word and clears the doorbell.
- Lets firmware run one network timestep per doorbell without knowing network timing.

Parameters:
- BRAM_ADDR_WIDTH, 32: BRAM byte-address width.
- BRAM_DATA_WIDTH, 128: BRAM word width; one spike bit per neuron.
- BYTES_PER_WIDTH, 16: byte-enable count, equal to BRAM_DATA_WIDTH/8.
- MAX_WORDS, 8: maximum spike words per direction (1024 neurons / 128).
- POLL_INTERVAL, 16: idle cycles between doorbell reads.

Ports:
- clk  in  1  system clock; also drives bram_clk.
- reset  in  1  asynchronous, active-low reset.
- bram_clk  out  1  equals clk.
- bram_addr  out  BRAM_ADDR_WIDTH  byte address; always 16-byte aligned.
- bram_din  out  BRAM_DATA_WIDTH  write data.
- bram_dout  in  BRAM_DATA_WIDTH  read data; valid 1 cycle after an en=1, we=0 cycle.
- bram_en  out  1  port enable.
- bram_rst  out  1  equals ~reset.
- bram_we  out  BYTES_PER_WIDTH  byte write enables.
- in_data  out  BRAM_DATA_WIDTH  input spike word to the network.
- in_valid  out  1  in_data valid.
- in_last  out  1  marks the final input word.
- in_ready  in  1  network accepts the input word.
- out_data  in  BRAM_DATA_WIDTH  output spike word from the network.
- out_valid  in  1  out_data valid.
- out_last  in  1  marks the final output word.
- out_ready  out  1  mailbox accepts the output word.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Word map (byte address = word index × 16):
  - W0 control: bit0 go; [15:8] n_in; [23:16] n_out.
  - W1 status: bit0 done; bit1 err; [15:8] words_out; [31:16] step_cnt.
  - W2 .. W2+MAX_WORDS-1: input spikes.
  - W2+MAX_WORDS ..: output spikes.
- Reset (reset=0, asynchronous): state=IDLE; bram_en=0, bram_we=0, bram_addr=0, bram_din=0; in_valid=0, in_last=0, out_ready=0, busy=0; step_cnt=0; poll timer=0.
- Reset mid-operation aborts with no BRAM cleanup. W0.go stays set, so the step reruns after reset.
- IDLE: count up to POLL_INTERVAL-1, then go to POLL_RD.
- POLL_RD: en=1, we=0, addr=W0, for 1 cycle. Go to POLL_CHK.
- POLL_CHK: sample bram_dout.
  - go=0: back to IDLE.
  - go=1 and both counts in 1..MAX_WORDS: latch n_in/n_out, err=0, go to LOAD_RD.
  - go=1 otherwise: err=1, words_out=0, go to CLR_WR.
- LOAD_RD: read W2+k for 1 cycle. Go to LOAD_CAP.
- LOAD_CAP: capture bram_dout into in_data; assert in_valid; in_last=(k==n_in-1). Go to LOAD_HS.
- LOAD_HS: hold in_data/in_valid/in_last stable until in_ready=1.
  - On the handshake cycle, drop in_valid and increment k.
  - k==n_in: go to COLLECT; otherwise go to LOAD_RD.
  - Minimum 3 cycles per input word.
- COLLECT: out_ready=1.
  - Each out_valid&&out_ready cycle drives en=1, we=all ones, addr=W(2+MAX_WORDS+j), din=out_data in the same cycle (combinational path from out_data to bram_din), then increments j.
  - Ends on out_last or when j reaches n_out.
  - Beats beyond n_out are impossible because out_ready drops once j==n_out.
  - Early out_last: words_out=j+1, with no error.
  - out_last after exactly n_out beats: words_out=n_out.
  - On exit, go to CLR_WR with out_ready=0.
- CLR_WR: write W0 with we=16'h0001 and din=0, clearing byte 0 (including go) only. Go to STAT_WR.
- STAT_WR: write W1 with we=16'h000F and din={step_cnt+1, words_out, 6'b0, err, 1'b1}.
  - step_cnt increments on every entry to STAT_WR, error or not, and wraps at 16 bits.
  - Return to IDLE with the poll timer cleared.
- bram_en is 0 in every cycle not listed above. bram_we is 0 on every read cycle.
- Simultaneous in_ready and state entry: in_ready is ignored unless in_valid is already high.

Decomposition:
- Package snn_mailbox_pkg holds:
  - state enum;
  - word-index constants CTRL_W, STAT_W, IN_BASE_W, OUT_BASE_W;
  - control/status field bit positions;
  - function word_addr(idx) returning idx<<4.
- No sub-module; one FSM with k/j counters and the poll timer.

Test Plan:
- W0 = 0x000000 for 100 cycles -> exactly one W0 read every POLL_INTERVAL+2 cycles; no writes; busy toggles only around the reads.
- W0 = 0x030201 (n_in=2, n_out=3), W2/W3 patterns, in_ready=1 -> in_data matches W2 then W3, in_last on the 2nd word only.
- Same run, network returns 3 words -> W10..W12 hold those words; W0 byte0 = 0; W1 = 0x00010301 (step 1, words_out 3, done).
- in_ready held low 20 cycles on word 0 -> in_data/in_valid stay stable; no BRAM read issued until the handshake.
- n_out=4 with out_last on beat 2 -> 2 words written; W1.words_out=2; err=0.
- W0 = 0x000901 (n_in=9 > MAX_WORDS) -> no stream activity; W1 = err|done; W0.go cleared.
- reset pulsed low during LOAD_HS -> all outputs reach reset values asynchronously; after release the step reruns from POLL_RD.

Source files
------------

// File: rtl/snn_mailbox_pkg.sv
// Shared types and constants for the BRAM spike mailbox.
// State encoding, word map indices, control/status field positions.
package snn_mailbox_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL_RD,
        S_POLL_CHK,
        S_LOAD_RD,
        S_LOAD_CAP,
        S_LOAD_HS,
        S_COLLECT,
        S_CLR_WR,
        S_STAT_WR
    } state_t;

    localparam int CTRL_W        = 0;
    localparam int STAT_W        = 1;
    localparam int IN_BASE_W     = 2;
    localparam int MAX_WORDS_DEF = 8;
    localparam int OUT_BASE_W    = IN_BASE_W + MAX_WORDS_DEF;

    localparam int GO_BIT    = 0;
    localparam int N_IN_LSB  = 8;
    localparam int N_OUT_LSB = 16;

    localparam int DONE_BIT  = 0;
    localparam int ERR_BIT   = 1;
    localparam int WORDS_LSB = 8;
    localparam int STEP_LSB  = 16;

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx << 4;
    endfunction

endpackage

// File: rtl/snn_bram_mailbox.sv
// BRAM port-B mailbox: polls W0 doorbell, streams input spike words to the
// network, writes returned spike words back, posts W1 status, clears W0.go.
// Ports: clk/reset, BRAM port B (bram_*), in_* stream out, out_* stream in, busy.
module snn_bram_mailbox
    import snn_mailbox_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH = 128,
    parameter int BYTES_PER_WIDTH = 16,
    parameter int MAX_WORDS       = 8,
    parameter int POLL_INTERVAL   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       bram_clk,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_din,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout,
    output logic                       bram_en,
    output logic                       bram_rst,
    output logic [BYTES_PER_WIDTH-1:0] bram_we,
    output logic [BRAM_DATA_WIDTH-1:0] in_data,
    output logic                       in_valid,
    output logic                       in_last,
    input  logic                       in_ready,
    input  logic [BRAM_DATA_WIDTH-1:0] out_data,
    input  logic                       out_valid,
    input  logic                       out_last,
    output logic                       out_ready,
    output logic                       busy
);

    localparam int OUT_W = IN_BASE_W + MAX_WORDS;

    state_t                     state;
    logic [15:0]                timer;
    logic [15:0]                step_cnt;
    logic [7:0]                 n_in, n_out, k, j, words_out;
    logic                       err;
    logic                       en_r;
    logic [BYTES_PER_WIDTH-1:0] we_r;
    logic [BRAM_ADDR_WIDTH-1:0] addr_r;
    logic [BRAM_DATA_WIDTH-1:0] din_r;

    logic       coll_wr;
    logic       go_f, cnt_ok;
    logic [7:0] nin_f, nout_f;
    logic [31:0] stat_w;

    assign nin_f  = bram_dout[N_IN_LSB +: 8];
    assign nout_f = bram_dout[N_OUT_LSB +: 8];
    assign go_f   = bram_dout[GO_BIT];
    assign cnt_ok = (nin_f != 8'd0) && (nin_f <= 8'(MAX_WORDS)) &&
                    (nout_f != 8'd0) && (nout_f <= 8'(MAX_WORDS));
    assign stat_w = {step_cnt + 16'd1, words_out, 6'b0, err, 1'b1};

    // Output beats are written straight through in the accepting cycle.
    assign coll_wr   = (state == S_COLLECT) && out_valid && out_ready;
    assign bram_clk  = clk;
    assign bram_rst  = ~reset;
    assign bram_en   = en_r | coll_wr;
    assign bram_we   = coll_wr ? '1 : we_r;
    assign bram_din  = coll_wr ? out_data : din_r;
    assign bram_addr = coll_wr ? BRAM_ADDR_WIDTH'(word_addr(32'(OUT_W) + 32'(j)))
                               : addr_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            step_cnt  <= '0;
            n_in      <= '0;
            n_out     <= '0;
            k         <= '0;
            j         <= '0;
            words_out <= '0;
            err       <= 1'b0;
            en_r      <= 1'b0;
            we_r      <= '0;
            addr_r    <= '0;
            din_r     <= '0;
            in_data   <= '0;
            in_valid  <= 1'b0;
            in_last   <= 1'b0;
            out_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            en_r <= 1'b0;
            we_r <= '0;
            unique case (state)
                S_IDLE: begin
                    if (timer == 16'(POLL_INTERVAL - 1)) begin
                        timer  <= '0;
                        state  <= S_POLL_RD;
                        busy   <= 1'b1;
                        en_r   <= 1'b1;
                        addr_r <= BRAM_ADDR_WIDTH'(word_addr(32'(CTRL_W)));
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_POLL_RD: state <= S_POLL_CHK;
                S_POLL_CHK: begin
                    if (!go_f) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt_ok) begin
                        n_in   <= nin_f;
                        n_out  <= nout_f;
                        k      <= '0;
                        j      <= '0;
                        err    <= 1'b0;
                        state  <= S_LOAD_RD;
                        en_r   <= 1'b1;
                        addr_r <= BRAM_ADDR_WIDTH'(word_addr(32'(IN_BASE_W)));
                    end else begin
                        err       <= 1'b1;
                        words_out <= '0;
                        state     <= S_CLR_WR;
                        en_r      <= 1'b1;
                        we_r      <= BYTES_PER_WIDTH'(1);
                        addr_r    <= BRAM_ADDR_WIDTH'(word_addr(32'(CTRL_W)));
                        din_r     <= '0;
                    end
                end
                S_LOAD_RD: state <= S_LOAD_CAP;
                S_LOAD_CAP: begin
                    in_data  <= bram_dout;
                    in_valid <= 1'b1;
                    in_last  <= (k == n_in - 8'd1);
                    state    <= S_LOAD_HS;
                end
                S_LOAD_HS: begin
                    if (in_ready) begin
                        in_valid <= 1'b0;
                        in_last  <= 1'b0;
                        k        <= k + 8'd1;
                        if (k + 8'd1 == n_in) begin
                            state     <= S_COLLECT;
                            out_ready <= 1'b1;
                        end else begin
                            state  <= S_LOAD_RD;
                            en_r   <= 1'b1;
                            addr_r <= BRAM_ADDR_WIDTH'(
                                word_addr(32'(IN_BASE_W) + 32'(k) + 32'd1));
                        end
                    end
                end
                S_COLLECT: begin
                    if (coll_wr) begin
                        j <= j + 8'd1;
                        if (out_last || (j + 8'd1 == n_out)) begin
                            words_out <= j + 8'd1;
                            out_ready <= 1'b0;
                            state     <= S_CLR_WR;
                            en_r      <= 1'b1;
                            we_r      <= BYTES_PER_WIDTH'(1);
                            addr_r    <= BRAM_ADDR_WIDTH'(word_addr(32'(CTRL_W)));
                            din_r     <= '0;
                        end
                    end
                end
                S_CLR_WR: begin
                    state    <= S_STAT_WR;
                    step_cnt <= step_cnt + 16'd1;
                    en_r     <= 1'b1;
                    we_r     <= BYTES_PER_WIDTH'(16'h000F);
                    addr_r   <= BRAM_ADDR_WIDTH'(word_addr(32'(STAT_W)));
                    din_r    <= BRAM_DATA_WIDTH'(stat_w);
                end
                S_STAT_WR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    timer <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_bram_mailbox.sv
// Directed bench for snn_bram_mailbox with a behavioural BRAM and network.
// Table-driven steps plus idle-poll, stall and mid-step reset sequences.
module tb_snn_bram_mailbox;

    logic         clk = 1'b0;
    logic         reset;
    logic         bram_clk;
    logic [31:0]  bram_addr;
    logic [127:0] bram_din;
    logic [127:0] bram_dout;
    logic         bram_en;
    logic         bram_rst;
    logic [15:0]  bram_we;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;

    always #5 clk = ~clk;

    snn_bram_mailbox dut (
        .clk(clk), .reset(reset), .bram_clk(bram_clk),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .bram_en(bram_en), .bram_rst(bram_rst), .bram_we(bram_we),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    logic [127:0] mem [0:31];
    logic         pre_we = 1'b0;
    int           pre_idx = 0;
    logic [127:0] pre_data = '0;

    int cyc = 0, last_rd = -1, bad_int = 0, w0_rd = 0, wr_cnt = 0;
    int bad_align = 0, stall_rd = 0, unstable = 0;
    logic         holding = 1'b0;
    logic [127:0] hold_d = '0;
    logic [127:0] rx_d[$];
    logic         rx_l[$];

    // Behavioural BRAM (1-cycle read latency, byte writes) plus stream monitor.
    always @(posedge clk) begin
        int idx;
        logic [127:0] w;
        cyc++;
        if (pre_we) mem[pre_idx] <= pre_data;
        if (bram_en) begin
            idx = int'(bram_addr[8:4]);
            if (bram_addr[3:0] != 4'd0) bad_align++;
            if (bram_we == 16'd0) begin
                bram_dout <= mem[idx];
                if (idx == 0) begin
                    w0_rd++;
                    if (last_rd >= 0 && cyc - last_rd != 18) bad_int++;
                    last_rd = cyc;
                end
            end else begin
                wr_cnt++;
                w = mem[idx];
                for (int b = 0; b < 16; b++)
                    if (bram_we[b]) w[b*8 +: 8] = bram_din[b*8 +: 8];
                mem[idx] <= w;
            end
        end
        if (bram_en && in_valid && !in_ready) stall_rd++;
        if (holding && (!in_valid || in_data != hold_d)) unstable++;
        holding = in_valid && !in_ready;
        hold_d  = in_data;
        if (in_valid && in_ready) begin
            rx_d.push_back(in_data);
            rx_l.push_back(in_last);
        end
    end

    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    function automatic logic [127:0] in_pat(input int v, input int i);
        return {4{32'hA500_0000 + 32'(v * 16 + i)}};
    endfunction

    function automatic logic [127:0] out_pat(input int v, input int i);
        return {4{32'h5A00_0000 + 32'(v * 16 + i)}};
    endfunction

    task automatic poke(input int idx, input logic [127:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive_out(input int v, input int nb, input int li);
        for (int i = 0; i < nb; i++) begin
            int t = 0;
            while (!out_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (!out_ready) begin
                total_cnt++;
                $display("FAIL out_ready_timeout actual=0 required=1");
                return;
            end
            out_valid = 1'b1;
            out_data  = out_pat(v, i);
            out_last  = (i == li);
            @(negedge clk);
            out_valid = 1'b0;
            out_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(mem[0][0] == 1'b0 && !busy) && t < 2000);
        if (t >= 2000) begin
            total_cnt++;
            $display("FAIL step_timeout actual=busy required=idle");
        end
    endtask

    task automatic load(input int v, input logic [23:0] ctrl);
        for (int i = 0; i < 8; i++) poke(2 + i, in_pat(v, i));
        for (int i = 0; i < 9; i++) poke(10 + i, '0);
        rx_d.delete();
        rx_l.delete();
        poke(0, {104'd0, ctrl});
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!in_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_valid) begin
            total_cnt++;
            $display("FAIL in_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"}, 128'(bram_en), 128'd0);
        chk({tag, "_we"}, 128'(bram_we), 128'd0);
        chk({tag, "_addr"}, 128'(bram_addr), 128'd0);
        chk({tag, "_din"}, bram_din, 128'd0);
        chk({tag, "_in_valid"}, 128'(in_valid), 128'd0);
        chk({tag, "_in_last"}, 128'(in_last), 128'd0);
        chk({tag, "_out_ready"}, 128'(out_ready), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_bram_rst"}, 128'(bram_rst), 128'd1);
    endtask

    typedef struct {
        logic [23:0] ctrl;
        int          nb;
        int          li;
        logic [31:0] stat;
        int          nrx;
        int          nw;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int busy_cnt;
        vecs[0] = '{24'h030201, 3, 2, 32'h0001_0301, 2, 3};
        vecs[1] = '{24'h040101, 2, 1, 32'h0002_0201, 1, 2};
        vecs[2] = '{24'h000901, 0, -1, 32'h0003_0003, 0, 0};
        vecs[3] = '{24'h020801, 2, -1, 32'h0004_0201, 8, 2};
        vecs[4] = '{24'h000101, 0, -1, 32'h0005_0003, 0, 0};
        vecs[5] = '{24'h080101, 8, 7, 32'h0006_0801, 1, 8};

        for (int i = 0; i < 32; i++) mem[i] = '0;
        bram_dout = '0;
        reset     = 1'b0;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        // Idle polling with go=0.
        reset   = 1'b1;
        last_rd = -1; bad_int = 0; w0_rd = 0; wr_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("idle_w0_reads", 128'(w0_rd), 128'd5);
        chk("idle_interval", 128'(bad_int), 128'd0);
        chk("idle_writes", 128'(wr_cnt), 128'd0);
        chk("idle_busy_cycles", 128'(busy_cnt), 128'd10);

        for (int v = 0; v < 6; v++) begin
            load(v, vecs[v].ctrl);
            fork
                drive_out(v, vecs[v].nb, vecs[v].li);
                wait_done();
            join
            chk($sformatf("v%0d_status", v), 128'(mem[1][31:0]), 128'(vecs[v].stat));
            chk($sformatf("v%0d_go_clr", v), 128'(mem[0][7:0]), 128'd0);
            chk($sformatf("v%0d_ctrl_kept", v), 128'(mem[0][23:8]),
                128'(vecs[v].ctrl[23:8]));
            chk($sformatf("v%0d_rx_cnt", v), 128'(rx_d.size()), 128'(vecs[v].nrx));
            for (int i = 0; i < rx_d.size() && i < vecs[v].nrx; i++) begin
                chk($sformatf("v%0d_rx%0d", v, i), rx_d[i], in_pat(v, i));
                chk($sformatf("v%0d_last%0d", v, i), 128'(rx_l[i]),
                    128'(i == vecs[v].nrx - 1));
            end
            for (int i = 0; i < vecs[v].nw; i++)
                chk($sformatf("v%0d_out%0d", v, i), mem[10 + i], out_pat(v, i));
            if (vecs[v].nw < 8)
                chk($sformatf("v%0d_out_extra", v), mem[10 + vecs[v].nw], 128'd0);
        end

        // Stall on word 0 for 20 cycles.
        in_ready = 1'b0;
        load(7, 24'h010201);
        wait_valid();
        chk("stall_word0", in_data, in_pat(7, 0));
        stall_rd = 0; unstable = 0;
        repeat (20) @(negedge clk);
        chk("stall_no_read", 128'(stall_rd), 128'd0);
        chk("stall_stable", 128'(unstable), 128'd0);
        chk("stall_valid", 128'(in_valid), 128'd1);
        in_ready = 1'b1;
        fork
            drive_out(7, 1, 0);
            wait_done();
        join
        chk("stall_status", 128'(mem[1][31:0]), 128'h0007_0101);
        chk("stall_rx_cnt", 128'(rx_d.size()), 128'd2);
        if (rx_d.size() == 2) chk("stall_rx1", rx_d[1], in_pat(7, 1));
        chk("stall_out0", mem[10], out_pat(7, 0));

        // Asynchronous reset while holding in LOAD_HS; step reruns.
        in_ready = 1'b0;
        load(9, 24'h010101);
        wait_valid();
        #2 reset = 1'b0;
        #1 chk_reset_outputs("arst");
        @(negedge clk);
        reset    = 1'b1;
        in_ready = 1'b1;
        fork
            drive_out(9, 1, 0);
            wait_done();
        join
        chk("rerun_status", 128'(mem[1][31:0]), 128'h0001_0101);
        chk("rerun_rx_cnt", 128'(rx_d.size()), 128'd1);
        if (rx_d.size() == 1) chk("rerun_rx0", rx_d[0], in_pat(9, 0));
        chk("rerun_out0", mem[10], out_pat(9, 0));
        chk("addr_align", 128'(bad_align), 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
